// File: rtl/serial_pattern_scanner.sv
// Word-to-bit sequencer wrapped around an overlapping Mealy "10010" detector.
// Scans a parallel word MSB-first and reports per-bit hit pulses plus a saturating hit count.
module serial_pattern_scanner #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] word_in,
    input  logic             keep_ctx,
    input  logic             abort,
    output logic             ready,
    output logic             busy,
    output logic             bit_out,
    output logic             hit,
    output logic [CNT_W-1:0] hit_count,
    output logic             done
);
    localparam int unsigned      BC_W     = $clog2(WIDTH + 1);
    localparam logic [4:0]       PATTERN  = 5'b10010;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [BC_W-1:0]  bit_cnt;
    logic [3:0]       hist;
    logic             match;

    always_comb begin
        ready   = (state == IDLE);
        busy    = (state != IDLE);
        bit_out = (state == SHIFT) ? shreg[WIDTH-1] : 1'b0;
        match   = (state == SHIFT) && ({hist, bit_out} == PATTERN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            hist      <= '0;
            hit_count <= '0;
            hit       <= 1'b0;
            done      <= 1'b0;
        end else begin
            hit  <= 1'b0;
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        shreg     <= word_in;
                        bit_cnt   <= '0;
                        hit_count <= '0;
                        if (!keep_ctx) hist <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Abort leaves the presented bit unconsumed and drops all detector history.
                    if (abort) begin
                        hist  <= '0;
                        state <= IDLE;
                    end else begin
                        shreg   <= {shreg[WIDTH-2:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                        hist    <= {hist[2:0], bit_out};
                        hit     <= match;
                        if (match && (hit_count != CNT_MAX)) hit_count <= hit_count + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_pattern_scanner.sv
// Self-checking bench for serial_pattern_scanner: directed cases plus random words, checked
// against a bit-history queue model; a second instance with CNT_W=2 covers saturation.
module tb_serial_pattern_scanner;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         keep_ctx = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] word_in = '0;

    logic       ready_a, busy_a, bit_a, hit_a, done_a;
    logic [4:0] cnt_a;
    logic       ready_b, busy_b, bit_b, hit_b, done_b;
    logic [1:0] cnt_b;

    int checks = 0;
    int errors = 0;
    int last_cnt = 0;
    int cyc = 0;
    bit q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    serial_pattern_scanner #(.WIDTH(W), .CNT_W(5)) dut_a (
        .clk(clk), .rst(rst), .start(start), .word_in(word_in), .keep_ctx(keep_ctx),
        .abort(abort), .ready(ready_a), .busy(busy_a), .bit_out(bit_a), .hit(hit_a),
        .hit_count(cnt_a), .done(done_a)
    );

    serial_pattern_scanner #(.WIDTH(W), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .word_in(word_in), .keep_ctx(keep_ctx),
        .abort(abort), .ready(ready_b), .busy(busy_b), .bit_out(bit_b), .hit(hit_b),
        .hit_count(cnt_b), .done(done_b)
    );

    function automatic int sat(input int c, input int m);
        return (c > m) ? m : c;
    endfunction

    // A match is the last five consumed bits reading 1,0,0,1,0; missing history counts as 0.
    function automatic bit model_match();
        logic [4:0] pat;
        int         n;
        int         idx;
        bit         b;
        pat = 5'b10010;
        n   = q.size();
        for (int i = 0; i < 5; i++) begin
            idx = n - 5 + i;
            b   = (idx >= 0) ? q[idx] : 1'b0;
            if (b != pat[4-i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag, input logic r, input logic b, input logic bo,
                             input logic h, input logic d, input int cnt);
        chk({tag, ".ready_a"}, 32'(ready_a), 32'(r));
        chk({tag, ".busy_a"},  32'(busy_a),  32'(b));
        chk({tag, ".bit_a"},   32'(bit_a),   32'(bo));
        chk({tag, ".hit_a"},   32'(hit_a),   32'(h));
        chk({tag, ".done_a"},  32'(done_a),  32'(d));
        chk({tag, ".cnt_a"},   32'(cnt_a),   32'(sat(cnt, 31)));
        chk({tag, ".ready_b"}, 32'(ready_b), 32'(r));
        chk({tag, ".busy_b"},  32'(busy_b),  32'(b));
        chk({tag, ".bit_b"},   32'(bit_b),   32'(bo));
        chk({tag, ".hit_b"},   32'(hit_b),   32'(h));
        chk({tag, ".done_b"},  32'(done_b),  32'(d));
        chk({tag, ".cnt_b"},   32'(cnt_b),   32'(sat(cnt, 3)));
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_all($sformatf("idle%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, last_cnt);
        end
    endtask

    // Called and returns at a falling edge with the DUT in IDLE. abort_at<0 means no abort;
    // poke holds start high (with junk words) and pulses abort outside SHIFT while busy.
    task automatic scan(input logic [W-1:0] w, input bit keep, input int abort_at,
                        input bit poke, input string tag);
        int cnt;
        bit exp_hit;
        bit m;
        check_all({tag, ".idle"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, last_cnt);
        if (!keep) q.delete();
        start    = 1'b1;
        word_in  = w;
        keep_ctx = keep;
        abort    = poke;
        @(negedge clk);
        abort   = 1'b0;
        cnt     = 0;
        exp_hit = 1'b0;
        for (int k = 0; k < W; k++) begin
            check_all($sformatf("%s.b%0d", tag, k), 1'b0, 1'b1, w[W-1-k], exp_hit, 1'b0, cnt);
            if (k == abort_at) begin
                abort = 1'b1;
                start = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                start = 1'b0;
                check_all({tag, ".abort"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cnt);
                q.delete();
                last_cnt = cnt;
                return;
            end
            q.push_back(w[W-1-k]);
            if (q.size() > 8) void'(q.pop_front());
            m       = model_match();
            exp_hit = m;
            cnt     = cnt + int'(m);
            start    = poke;
            word_in  = W'($urandom);
            keep_ctx = 1'($urandom);
            @(negedge clk);
        end
        check_all({tag, ".done"}, 1'b0, 1'b1, 1'b0, exp_hit, 1'b1, cnt);
        last_cnt = cnt;
        abort    = poke;
        @(negedge clk);
        abort = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] rw;
        bit           rk;
        int           ra;
        int           t0;
        int           t1;

        #12;
        check_all("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        scan(16'h9200, 1'b0, -1, 1'b0, "t1");
        idle(2);
        scan(16'h0009, 1'b0, -1, 1'b0, "t2a");
        scan(16'h0000, 1'b1, -1, 1'b0, "t2b");
        scan(16'h0009, 1'b0, -1, 1'b0, "t2c");
        scan(16'h0000, 1'b0, -1, 1'b0, "t2d");
        scan(16'h9249, 1'b0, -1, 1'b0, "t3");
        scan(16'h9200, 1'b0, 6, 1'b0, "t4a");
        scan(16'h9000, 1'b1, -1, 1'b0, "t4b");
        scan(16'h9200, 1'b0, -1, 1'b1, "t5a");
        t0 = cyc;
        scan(16'h9249, 1'b0, -1, 1'b1, "t5b");
        t1 = cyc;
        scan(16'h9200, 1'b1, -1, 1'b1, "t5c");
        chk("b2b_period", 32'(t1 - t0), 32'd18);
        idle(1);

        // Asynchronous reset in the middle of a scan, away from any clock edge.
        start    = 1'b1;
        word_in  = 16'h9249;
        keep_ctx = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #3 rst = 1'b1;
        #1 check_all("t6.rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        last_cnt = 0;
        idle(3);
        scan(16'h9200, 1'b0, -1, 1'b0, "t6b");

        for (int i = 0; i < 24; i++) begin
            rw = W'($urandom);
            if (i % 3 == 0) rw = rw | 16'h9248;
            rk = 1'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1;
            scan(rw, rk, ra, 1'($urandom), $sformatf("rnd%0d", i));
            if ($urandom_range(0, 2) == 0) idle(1);
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
